// File: rtl/fht_pkg.sv
// ---------------------------------------------------------------------------
// fht_pkg
// Shared definitions for the FHT front-end blocks (input loader, output
// unloader).
//   - loader_state_e   : loader FSM state encoding
//   - bank_size()      : words per data bank for a given bank address width
//   - n_points()       : transform length (four banks)
//   - bitrev()         : bit reversal of the low 'width' bits of a value
//   - bank_onehot()    : bank index to one-hot write enable
//   - WAIT_LOW_TIMEOUT : cycles the loader waits for the FHT core to drop RDY
// ---------------------------------------------------------------------------
package fht_pkg;

  localparam int A_BIT_DEFAULT    = 8;
  localparam int D_BIT_DEFAULT    = 16;
  localparam int WAIT_LOW_TIMEOUT = 16;

  // Widest value bitrev() can handle; callers zero-extend into this width.
  localparam int BITREV_MAX_W = 32;
  localparam int BITREV_IDX_W = $clog2(BITREV_MAX_W);

  typedef enum logic [2:0] {
    LD_LOAD      = 3'd0,
    LD_FLUSH     = 3'd1,
    LD_KICK      = 3'd2,
    LD_WAIT_LOW  = 3'd3,
    LD_WAIT_HIGH = 3'd4
  } loader_state_e;

  function automatic int bank_size(input int a_bit);
    return 1 << a_bit;
  endfunction

  function automatic int n_points(input int a_bit);
    return 4 * bank_size(a_bit);
  endfunction

  // Reverses bits [width-1:0] of value; result bits at and above width are 0.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] value,
    input int                      width
  );
    logic [BITREV_MAX_W-1:0] rev;
    logic [BITREV_IDX_W-1:0] src;
    rev = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) begin
        src    = BITREV_IDX_W'(width - 1 - i);
        rev[i] = value[src];
      end
    end
    return rev;
  endfunction

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/fht_addr_bitrev.sv
// ---------------------------------------------------------------------------
// fht_addr_bitrev
// Maps a linear sample index to its bit-reversed location in the four FHT
// data banks. Purely combinational; shared by the input loader and the
// output unloader.
// Ports:
//   count  in  A_BIT+2  linear sample index
//   bank   out 2        bank select (top two bits of the reversed index)
//   addr   out A_BIT    word address inside the bank
// ---------------------------------------------------------------------------
module fht_addr_bitrev
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEFAULT
) (
  input  logic [A_BIT+1:0] count,
  output logic [1:0]       bank,
  output logic [A_BIT-1:0] addr
);

  localparam int CNT_W = A_BIT + 2;

  logic [BITREV_MAX_W-1:0]       count_ext;
  logic [BITREV_MAX_W-CNT_W-1:0] rev_unused;
  logic [CNT_W-1:0]              rev;

  assign count_ext          = {{(BITREV_MAX_W - CNT_W){1'b0}}, count};
  assign {rev_unused, rev}  = bitrev(count_ext, CNT_W);

  assign bank = rev[CNT_W-1:A_BIT];
  assign addr = rev[A_BIT-1:0];

endmodule

// File: rtl/fht_input_loader.sv
// ---------------------------------------------------------------------------
// fht_input_loader
// Collects one frame of N = 4*2^A_BIT samples from a valid/ready stream,
// writes each sample into the four FHT data banks at its bit-reversed
// location, starts fht_control, and holds off input until the conversion's
// RDY low/high cycle has completed.
//
// Ports:
//   iCLK      in  1      clock
//   iRESET    in  1      synchronous active-high reset
//   iDATA     in  D_BIT  input sample
//   iVALID    in  1      iDATA valid
//   iSOP      in  1      first sample of a frame (qualified by iVALID)
//   oREADY    out 1      a sample is accepted this cycle if iVALID is high
//   iFHT_RDY  in  1      fht_control idle flag
//   oADDR_WR  out A_BIT  bank write address
//   oWE       out 4      one-hot bank write enable (bit k = bank k)
//   oDATA     out D_BIT  write data
//   oSTART    out 1      single-cycle start pulse to fht_control
//   oBUSY     out 1      frame in progress or conversion outstanding
//   oERR      out 1      sticky frame/handshake error, cleared by reset
//
// state     | meaning
// ----------+---------------------------------------------------------------
// LOAD      | accepting samples, n = index of next sample
// FLUSH     | last sample's registered write is on the bank bus
// KICK      | oSTART pulse to fht_control
// WAIT_LOW  | waiting for RDY to drop; gives up after WAIT_LOW_TIMEOUT
// WAIT_HIGH | conversion running, waiting for RDY to return
// ---------------------------------------------------------------------------
module fht_input_loader
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEFAULT,
  parameter int D_BIT = D_BIT_DEFAULT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  input  logic             iSOP,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic [D_BIT-1:0] oDATA,
  output logic             oSTART,
  output logic             oBUSY,
  output logic             oERR
);

  localparam int               CNT_W    = A_BIT + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(n_points(A_BIT) - 1);
  localparam int               TMR_W    = $clog2(WAIT_LOW_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WAIT_LOW_TIMEOUT - 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;

  logic             ready_c;
  logic             start_c;
  logic             accept;
  logic [CNT_W-1:0] idx;
  logic [1:0]       wr_bank;
  logic [A_BIT-1:0] wr_addr;

  logic [3:0]       we_q;
  logic [A_BIT-1:0] addr_q;
  logic [D_BIT-1:0] data_q;

  fht_addr_bitrev #(
    .A_BIT (A_BIT)
  ) u_addr_bitrev (
    .count (idx),
    .bank  (wr_bank),
    .addr  (wr_addr)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    timer_d = timer_q;
    err_d   = err_q;
    ready_c = 1'b0;
    start_c = 1'b0;
    accept  = 1'b0;
    idx     = n_q;

    unique case (state_q)
      LD_LOAD: begin
        ready_c = 1'b1;
        accept  = iVALID;
        if (iVALID) begin
          // A start-of-packet always (re)starts the frame at sample 0.
          idx = iSOP ? '0 : n_q;
          // Error when SOP lands mid-frame or is missing on sample 0.
          if (iSOP != (n_q == '0)) begin
            err_d = 1'b1;
          end
          n_d = idx + CNT_W'(1);
          if (idx == LAST_IDX) begin
            state_d = LD_FLUSH;
          end
        end
      end

      LD_FLUSH: begin
        state_d = LD_KICK;
      end

      LD_KICK: begin
        start_c = 1'b1;
        timer_d = TMR_LOAD;
        state_d = LD_WAIT_LOW;
      end

      LD_WAIT_LOW: begin
        if (!iFHT_RDY) begin
          state_d = LD_WAIT_HIGH;
        end else if (timer_q == '0) begin
          // Core never acknowledged the start; drop the frame.
          err_d   = 1'b1;
          state_d = LD_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      LD_WAIT_HIGH: begin
        if (iFHT_RDY) begin
          state_d = LD_LOAD;
        end
      end

      default: begin
        state_d = LD_LOAD;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= LD_LOAD;
      n_q     <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      we_q    <= accept ? bank_onehot(wr_bank) : 4'b0000;
      if (accept) begin
        addr_q <= wr_addr;
        data_q <= iDATA;
      end
    end
  end

  assign oREADY   = ready_c;
  assign oSTART   = start_c;
  // n only returns to 0 outside LOAD or before the first accepted sample.
  assign oBUSY    = (state_q != LD_LOAD) || (n_q != '0);
  assign oERR     = err_q;
  assign oWE      = we_q;
  assign oADDR_WR = addr_q;
  assign oDATA    = data_q;

endmodule

// File: tb/tb_fht_input_loader.sv
module tb_fht_input_loader;

  localparam int A  = 2;
  localparam int DW = 16;
  localparam int BS = 1 << A;
  localparam int N  = 4 * BS;

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic [DW-1:0] iDATA;
  logic          iVALID;
  logic          iSOP;
  logic          oREADY;
  logic          iFHT_RDY;
  logic [A-1:0]  oADDR_WR;
  logic [3:0]    oWE;
  logic [DW-1:0] oDATA;
  logic          oSTART;
  logic          oBUSY;
  logic          oERR;

  fht_input_loader #(
    .A_BIT (A),
    .D_BIT (DW)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iDATA    (iDATA),
    .iVALID   (iVALID),
    .iSOP     (iSOP),
    .oREADY   (oREADY),
    .iFHT_RDY (iFHT_RDY),
    .oADDR_WR (oADDR_WR),
    .oWE      (oWE),
    .oDATA    (oDATA),
    .oSTART   (oSTART),
    .oBUSY    (oBUSY),
    .oERR     (oERR)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next expected sample index and sticky error.
  int m_n   = 0;
  bit m_err = 1'b0;
  bit seen[N];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Location of sample k: its index read MSB-first as an (A+2)-bit number.
  function automatic int ref_rev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < A + 2; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(oREADY),   1);
    check({tag, "_we"},    32'(oWE),      0);
    check({tag, "_start"}, 32'(oSTART),   0);
    check({tag, "_busy"},  32'(oBUSY),    0);
    check({tag, "_err"},   32'(oERR),     0);
    check({tag, "_addr"},  32'(oADDR_WR), 0);
    check({tag, "_data"},  32'(oDATA),    0);
  endtask

  task automatic do_reset(input string tag);
    iVALID = 1'b0;
    iSOP   = 1'b0;
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    check_idle_outputs(tag);
    m_n   = 0;
    m_err = 1'b0;
  endtask

  task automatic idle();
    iVALID = 1'b0;
    iSOP   = 1'($urandom_range(0, 1));
    iDATA  = 16'($urandom);
    tick();
    check("gap_we", 32'(oWE), 0);
    check("gap_start", 32'(oSTART), 0);
    iSOP = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sop, output bit last);
    int idx;
    int r;
    int guard;
    guard = 0;
    while (oREADY !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    check("ready_before_send", 32'(oREADY), 1);
    iVALID = 1'b1;
    iDATA  = d;
    iSOP   = sop;
    idx    = sop ? 0 : m_n;
    if ((sop && m_n != 0) || (!sop && m_n == 0)) m_err = 1'b1;
    r = ref_rev(idx);
    tick();
    iVALID = 1'b0;
    iSOP   = 1'b0;
    iDATA  = 16'($urandom);
    check("wr_we",   32'(oWE),      1 << (r / BS));
    check("wr_addr", 32'(oADDR_WR), r % BS);
    check("wr_data", 32'(oDATA),    32'(d));
    check("wr_busy", 32'(oBUSY),    1);
    check("wr_err",  32'(oERR),     32'(m_err));
    check("wr_no_start", 32'(oSTART), 0);
    seen[r] = 1'b1;
    m_n  = (idx + 1) % N;
    last = (idx == N - 1);
  endtask

  // Checks that oSTART follows the last write by exactly one cycle; leaves
  // the bench sampling in the KICK cycle.
  task automatic check_kick();
    check("flush_no_start", 32'(oSTART), 0);
    check("flush_ready", 32'(oREADY), 0);
    tick();
    check("kick_start", 32'(oSTART), 1);
    check("kick_we", 32'(oWE), 0);
  endtask

  task automatic run_frame(input bit gaps, input bit rand_data, input bit spot);
    bit last;
    int cnt;
    last = 1'b0;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle();
      end
      send(rand_data ? 16'($urandom) : 16'(k), k == 0, last);
      if (spot && k == 1) begin
        check("n1_we", 32'(oWE), 32'h4);
        check("n1_addr", 32'(oADDR_WR), 0);
      end
      if (spot && k == 4) begin
        check("n4_we", 32'(oWE), 32'h1);
        check("n4_addr", 32'(oADDR_WR), 2);
      end
      if (spot && k == 13) begin
        check("n13_we", 32'(oWE), 32'h4);
        check("n13_addr", 32'(oADDR_WR), 3);
      end
    end
    check("frame_last", 32'(last), 1);
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(seen[i]);
    check("unique_pairs", 32'(cnt), N);
    check_kick();
  endtask

  // fht_control model: RDY drops 2 cycles after oSTART for 40 cycles.
  task automatic convert_normal();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("conv_pre_ready", 32'(oREADY), 0);
    end
    iFHT_RDY = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("conv_ready", 32'(oREADY), 0);
      check("conv_busy", 32'(oBUSY), 1);
      check("conv_start_once", 32'(oSTART), 0);
    end
    iFHT_RDY = 1'b1;
    check("rdy_rise_ready", 32'(oREADY), 0);
    tick();
    check("after_rdy_ready", 32'(oREADY), 1);
    check("after_rdy_busy", 32'(oBUSY), 0);
  endtask

  initial begin
    bit last;
    int accepts;

    iRESET   = 1'b1;
    iDATA    = '0;
    iVALID   = 1'b0;
    iSOP     = 1'b0;
    iFHT_RDY = 1'b1;
    tick();
    tick();
    iRESET = 1'b0;
    check_idle_outputs("por");

    // Back-to-back frame 0..15, then a second frame of random data.
    run_frame(1'b0, 1'b0, 1'b1);
    convert_normal();
    run_frame(1'b0, 1'b1, 1'b0);
    convert_normal();

    // Same 0..15 sequence with random idle gaps.
    run_frame(1'b1, 1'b0, 1'b1);
    convert_normal();

    // SOP re-asserted at n = 7 restarts the frame.
    for (int k = 0; k < 7; k++) send(16'(k), k == 0, last);
    check("pre_sop_err", 32'(oERR), 0);
    send(16'h7777, 1'b1, last);
    check("sop7_err", 32'(oERR), 1);
    check("sop7_we", 32'(oWE), 32'h1);
    check("sop7_addr", 32'(oADDR_WR), 0);
    accepts = 1;
    while (!last && accepts < 40) begin
      send(16'($urandom), 1'b0, last);
      accepts++;
    end
    check("sop7_accepts", 32'(accepts), 16);
    check_kick();
    convert_normal();
    check("err_sticky", 32'(oERR), 1);

    // fht_control never drops RDY: abort after the timeout.
    do_reset("rst_a");
    run_frame(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("to_ready", 32'(oREADY), 0);
      check("to_err", 32'(oERR), 0);
    end
    tick();
    check("to_abort_err", 32'(oERR), 1);
    check("to_abort_ready", 32'(oREADY), 1);
    check("to_abort_busy", 32'(oBUSY), 0);

    // Missing SOP on the first sample.
    do_reset("rst_b");
    send(16'h1234, 1'b0, last);
    check("nosop_err", 32'(oERR), 1);
    check("nosop_we", 32'(oWE), 32'h1);

    // Reset mid-frame at n = 9.
    do_reset("rst_c");
    for (int k = 0; k < 9; k++) send(16'($urandom), k == 0, last);
    do_reset("rst_n9");
    run_frame(1'b0, 1'b1, 1'b0);
    convert_normal();

    // Reset during WAIT_HIGH.
    run_frame(1'b0, 1'b1, 1'b0);
    tick();
    iFHT_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wh_ready", 32'(oREADY), 0);
    end
    do_reset("rst_wh");
    iFHT_RDY = 1'b1;
    run_frame(1'b1, 1'b1, 1'b0);
    convert_normal();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fht_input_loader.md
Name: fht_input_loader

Overview:
- Upstream feeder for fht_control.
- Accepts one frame of N = 4*2^A_BIT real samples over a valid/ready stream and writes each sample into the four FHT data banks in bit-reversed order.
- When the frame is complete, pulses iSTART of fht_control, then holds off input until the conversion's RDY cycle (low, then high again) has finished.
- Output write bus drives bank port set A, muxed by the top-level with fht_control's writes.

Parameters:
- A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT, N = 4*BANK_SIZE points.
- D_BIT, 16, sample width, two's complement.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset; one clock; reset is synchronous and active-high.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  iDATA valid.
- iSOP  in  1  first sample of frame, qualified by iVALID.
- oREADY  out  1  loader accepts a sample this cycle.
- iFHT_RDY  in  1  oRDY of fht_control; high = idle.
- oADDR_WR  out  A_BIT  bank write address.
- oWE  out  4  one-hot bank write enable, bit k = bank k.
- oDATA  out  D_BIT  write data.
- oSTART  out  1  one-cycle start pulse to fht_control.
- oBUSY  out  1  high from first accepted sample until conversion complete.
- oERR  out  1  sticky frame error flag.

Behaviour:
- Accept condition: iVALID & oREADY. oREADY = 1 only in LOAD, combinational from state.
- Sample counter n: A_BIT+2 bits.
- Bit reversal: r = bit-reverse of n over A_BIT+2 bits.
  - Bank = r[A_BIT+1:A_BIT].
  - oADDR_WR = r[A_BIT-1:0].
- Write latency: registered. oWE/oADDR_WR/oDATA are valid the cycle after acceptance; oWE = 0 otherwise.
- States:
  - LOAD: n counts accepted samples.
    - If iSOP is accepted while n != 0: set oERR, restart at n = 0 with this sample written as sample 0.
    - If iSOP is low on the first sample (n = 0): set oERR, sample still written as sample 0.
    - On acceptance with n = N-1: n wraps to 0, go to KICK.
  - KICK: one cycle after the last write (last oWE cycle). oSTART = 1; go to WAIT_LOW.
  - WAIT_LOW: wait for iFHT_RDY = 0, then go to WAIT_HIGH.
    - If iFHT_RDY stays 1 for 16 cycles: set oERR, go to LOAD (abort).
  - WAIT_HIGH: wait for iFHT_RDY = 1, then go to LOAD.
- oBUSY:
  - 0 in LOAD while n = 0.
  - 1 from the first accepted sample until the WAIT_HIGH exit.
- Reset, any state, mid-frame or mid-conversion:
  - State = LOAD, n = 0.
  - oWE = 0, oSTART = 0, oBUSY = 0, oERR = 0.
  - oADDR_WR = 0, oDATA = 0.
  - A partial frame is discarded.
- oERR clears only on reset.
- iVALID low mid-frame: counter holds, no write; gaps are unlimited.
- Inputs while oREADY = 0 are ignored; iSOP without iVALID is ignored.
- Throughput: one sample per cycle in LOAD.
  - Frame cost: N load cycles, +1 flush, +1 KICK, + conversion time.

Decomposition:
- Shared package fht_pkg:
  - Loader state enum.
  - BANK_SIZE, N_POINTS derived from A_BIT.
  - bitrev function, parameterised width.
  - WAIT_LOW timeout constant = 16.
- Sub-module fht_addr_bitrev: counter value to {bank, addr}, combinational. Reused by the output unloader.

Test Plan:
- A_BIT=2 (N=16): feed samples 0..15 back-to-back, iSOP on the first.
  - n=1 -> bank 2, addr 0. n=4 -> bank 0, addr 2. n=13 -> bank 2, addr 3.
  - All 16 {bank,addr} pairs unique.
  - oSTART pulses exactly once, one cycle after the last oWE.
- Model fht_control RDY (low 40 cycles, 2 cycles after oSTART):
  - oREADY = 0 throughout.
  - oREADY returns 1 the cycle after RDY rises.
  - Second frame loads correctly.
- Random iVALID gaps (≈50%): same bank/address/data sequence as the back-to-back case; no write on idle cycles.
- iSOP asserted at n = 7:
  - oERR = 1.
  - That sample written to bank 0, addr 0.
  - Frame then requires 16 further accepts (including that sample) before oSTART.
- iFHT_RDY held at 1 after oSTART: after 16 cycles oERR = 1, state LOAD, oREADY = 1.
- Reset asserted at n = 9 and again during WAIT_HIGH:
  - Next cycle all outputs are 0 except oREADY = 1.
  - The next frame starts at n = 0 with no spurious oSTART.
